sa_port_arbiter: RTL and testbench

SA_PORT_ARBITER -- requirements
Module: sa_port_arbiter

---
 rtl/sa_port_arbiter.sv | 103 ++++++++++
 tb/tb_sa_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sa_port_arbiter.sv
// Purpose  : 4-input round-robin arbiter (L/N/E/S) feeding one downstream port, with a stall alarm.
// Latency  : grant is combinational in the request cycle; data_out/valid_out follow one cycle later.
// Backpr.  : full_in=1 blocks every grant; blocked cycles are counted and raise stall_alarm at STALL_LIMIT.
// Ports    : clk, rst_n (async, active-low); req[3:0] (bit0 L, 1 N, 2 E, 3 S);
//            L/N/E/S_data_in flits; full_in; grant[3:0] one-hot accept; data_out/valid_out registered flit;
//            rr_ptr current highest-priority index (debug); stall_alarm registered blocked-too-long flag.
module sa_port_arbiter #(
   parameter int DATASIZE    = 40,
   parameter int STALL_LIMIT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          req,
   input  logic [DATASIZE-1:0] L_data_in,
   input  logic [DATASIZE-1:0] N_data_in,
   input  logic [DATASIZE-1:0] E_data_in,
   input  logic [DATASIZE-1:0] S_data_in,
   input  logic                full_in,
   output logic [3:0]          grant,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   output logic [1:0]          rr_ptr,
   output logic                stall_alarm
);

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   logic [DATASIZE-1:0] r_data;
   logic                r_valid;
   logic [1:0]          r_rr_ptr;
   logic [7:0]          r_stall_cnt;
   logic                r_stall_alarm;

   logic                w_found;
   logic [1:0]          w_win_idx;
   logic                w_grant_en;
   logic [DATASIZE-1:0] w_sel_data;
   logic [7:0]          w_cnt_next;

   // Rotating priority search: offset 0 is rr_ptr itself, wrapping modulo 4.
   always_comb begin : rr_search
      logic [1:0] idx;
      w_found   = 1'b0;
      w_win_idx = 2'd0;
      idx       = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = r_rr_ptr + 2'(k);
         if (!w_found && req[idx]) begin
            w_found   = 1'b1;
            w_win_idx = idx;
         end
      end
   end

   // rst_n gates the grant so nothing is accepted (and consumed) while reset is held.
   assign w_grant_en = w_found & ~full_in & rst_n;
   assign grant      = w_grant_en ? (4'b0001 << w_win_idx) : 4'b0000;

   always_comb begin
      w_sel_data = L_data_in;
      case (w_win_idx)
         2'd0:    w_sel_data = L_data_in;
         2'd1:    w_sel_data = N_data_in;
         2'd2:    w_sel_data = E_data_in;
         default: w_sel_data = S_data_in;
      endcase
   end

   // Counter only runs while someone waits behind full_in; any grant or an idle cycle resets it.
   always_comb begin
      w_cnt_next = r_stall_cnt;
      if (w_grant_en || (req == 4'b0000)) begin
         w_cnt_next = 8'd0;
      end else if (full_in && (r_stall_cnt != LIMIT)) begin
         w_cnt_next = r_stall_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_rr_ptr      <= 2'd0;
         r_stall_cnt   <= 8'd0;
         r_stall_alarm <= 1'b0;
      end else begin
         r_valid <= w_grant_en;
         if (w_grant_en) begin
            r_data   <= w_sel_data;
            r_rr_ptr <= w_win_idx + 2'd1;
         end
         r_stall_cnt <= w_cnt_next;
         // Registered from the next counter value so the flag tracks the counter cycle-for-cycle.
         r_stall_alarm <= (w_cnt_next == LIMIT);
      end
   end

   assign data_out    = r_data;
   assign valid_out   = r_valid;
   assign rr_ptr      = r_rr_ptr;
   assign stall_alarm = r_stall_alarm;

endmodule

// File: tb/tb_sa_port_arbiter.sv
module tb_sa_port_arbiter;

   localparam int DW = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [DW-1:0] L_data_in, N_data_in, E_data_in, S_data_in;
   logic          full_in;
   logic [3:0]    grant;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [1:0]    rr_ptr;
   logic          stall_alarm;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_data;
   logic [3:0]    prev_eg;
   int unsigned   seq = 0;

   sa_port_arbiter #(.DATASIZE(DW), .STALL_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .L_data_in(L_data_in), .N_data_in(N_data_in),
      .E_data_in(E_data_in), .S_data_in(S_data_in),
      .full_in(full_in), .grant(grant), .data_out(data_out),
      .valid_out(valid_out), .rr_ptr(rr_ptr), .stall_alarm(stall_alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req_v, $time);
      end
   endtask

   // Monitor: every valid_out must match the oldest expected flit.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: data_out=%0h with no flit expected at %0t", data_out, $time);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL flit_data: actual=%0h required=%0h at %0t", data_out, e, $time);
            end
         end
      end
   end

   // One cycle: drive inputs just after the edge, check at the falling edge.
   task automatic step(input logic [3:0] rq, input logic fl, input logic [3:0] eg,
                       input logic [1:0] ep, input logic ea);
      logic [DW-1:0] d;
      @(posedge clk);
      #1;
      seq++;
      req       = rq;
      full_in   = fl;
      L_data_in = {8'hA0, 32'(seq)};
      N_data_in = {8'hB1, 32'(seq)};
      E_data_in = {8'hC2, 32'(seq)};
      S_data_in = {8'hD3, 32'(seq)};
      @(negedge clk);
      if (prev_eg == 4'b0000) begin
         chk("idle_valid", 64'(valid_out), 64'd0);
         chk("idle_hold", 64'(data_out), 64'(last_data));
      end
      chk("rr_ptr", 64'(rr_ptr), 64'(ep));
      chk("grant", 64'(grant), 64'(eg));
      chk("stall_alarm", 64'(stall_alarm), 64'(ea));
      d = '0;
      case (eg)
         4'b0001: d = L_data_in;
         4'b0010: d = N_data_in;
         4'b0100: d = E_data_in;
         4'b1000: d = S_data_in;
         default: d = '0;
      endcase
      if (eg != 4'b0000) begin
         exp_q.push_back(d);
         last_data = d;
      end
      prev_eg = eg;
   endtask

   initial begin
      logic [3:0] rot [4];
      rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000;
      last_data = '0;
      prev_eg   = 4'b0000;
      rst_n = 1'b0;
      req = 4'b1111;
      full_in = 1'b0;
      L_data_in = '0; N_data_in = '0; E_data_in = '0; S_data_in = '0;

      // Reset state, with requests present
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_data", 64'(data_out), 64'd0);
      chk("rst_ptr", 64'(rr_ptr), 64'd0);
      chk("rst_alarm", 64'(stall_alarm), 64'd0);
      req = 4'b0000;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // All four requesting: strict rotation L,N,E,S,...
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, rot[i % 4], 2'(i % 4), 1'b0);

      // Wrap 3->0 then 0->1 with req=1001
      step(4'b0010, 1'b0, 4'b0010, 2'd0, 1'b0);
      step(4'b1001, 1'b0, 4'b1000, 2'd2, 1'b0);
      step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

      // Stall: 20 blocked cycles, alarm from the 16th cycle on
      for (int k = 1; k <= 20; k++) step(4'b0010, 1'b1, 4'b0000, 2'd1, (k >= 16));
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
      step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

      // full_in rising together with a new request: no grant
      step(4'b1000, 1'b1, 4'b0000, 2'd2, 1'b0);

      // full_in toggling with E requesting: grant every other cycle, data held between
      step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
      step(4'b0100, 1'b1, 4'b0000, 2'd3, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 2'd3, 1'b0);
      step(4'b0100, 1'b1, 4'b0000, 2'd3, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 2'd3, 1'b0);
      step(4'b0001, 1'b0, 4'b0001, 2'd3, 1'b0);

      // Async reset while the last flit is being presented
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = 4'b1111;
      exp_q.delete();
      #1;
      chk("midrst_valid", 64'(valid_out), 64'd0);
      chk("midrst_data", 64'(data_out), 64'd0);
      chk("midrst_ptr", 64'(rr_ptr), 64'd0);
      chk("midrst_grant", 64'(grant), 64'd0);
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk);
      #1 rst_n = 1'b1;
      last_data = '0;
      prev_eg   = 4'b0000;
      step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

      // Single continuous requester granted every cycle, starting from rr_ptr=0
      step(4'b0100, 1'b0, 4'b0100, 2'd0, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 2'd3, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 2'd3, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

      chk("flits_outstanding", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
